mdu_iter: RTL
=============

# mdu_iter

Parametrised iterative multiply/divide unit for the EX stage of the MIPS pipeline. It generalises the fixed 32-bit MDU: data width is configurable, multiply throughput is selectable, and it adds a start/busy/done handshake, stall freeze, flush cancel and defined divide-by-zero and overflow results. The datapath drives it from EX and stalls the pipe on `busy`. Results go to HI/LO, held internally when `MDU_HILO_EN` is defined.

## Interface
- `WIDTH`, default 32: operand width. Must be even and at least 8.
- `MUL_BITS`, default 1: multiplier bits consumed per cycle. Allowed values are 1, 2 and 4; `WIDTH % MUL_BITS == 0`.
- `clk`  in  1  clock. Everything updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  stage enable, equal to ~StallE. Low freezes all state.
- `flush`  in  1  cancel. Has priority over `en` and `start`.
- `start`  in  1  request. Accepted only when `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`, `src_b`  in  WIDTH  operands; latched on accept.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `res_hi`, `res_lo`  out  WIDTH  product high/low, or remainder/quotient. Held until the next `done`.
- `div_zero`  out  1  last division had divisor 0. Held like the results.
- `hilo_we`  in  2  present only with `MDU_HILO_EN`. Bit1 writes HI (MTHI), bit0 writes LO (MTLO).
- `hilo_wdata`  in  WIDTH  present only with `MDU_HILO_EN`.
- `hi`, `lo`  out  WIDTH  architectural HI/LO, present only with `MDU_HILO_EN`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE/DONE:
  - `start`=1 with `en`=1 latches operands and op.
  - Signed ops take magnitudes and record the result signs.
  - Transition to MUL or DIV. If the op is a division and `src_b`=0, go straight to FIX.
- MUL: shift-add, `MUL_BITS` bits per cycle, for N=WIDTH/MUL_BITS cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, for N=WIDTH cycles, then FIX.
- FIX: apply signs and write the `res_*` registers, then go to DONE.
  - MULT: 2·WIDTH-bit two's-complement product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- DONE: `done`=1 for this one cycle, then IDLE unless a new `start` is accepted in the same cycle.
- Boundary rules:
  - Divide by zero: `res_hi`=`src_a`, `res_lo`=all ones, `div_zero`=1.
  - Signed MIN/−1: `res_lo`=MIN, `res_hi`=0, `div_zero`=0. No trap.
  - `start` while `busy`: ignored. No queueing.
  - `flush`=1: state goes to IDLE next edge and no `done` is produced. `res_*` and `div_zero` are unchanged.
  - `en`=0: state, counter and partials all hold. A `done` that is due is delayed; it is not lost.
- Reset:
  - State IDLE.
  - `busy`, `done`, `div_zero` = 0.
  - `res_hi`, `res_lo`, `hi`, `lo` = 0.

## Timing
- The accept cycle is cycle 0.
- `busy` is high in cycles 1..N+1. FIX is cycle N+1 and is included.
- `done` is high in cycle N+2, with `busy`=0.
- With WIDTH=32, MUL_BITS=1: multiply and divide both pulse `done` at cycle 34.
- Divide by zero: FIX in cycle 1, `done` in cycle 2.
- Every cycle with `en`=0 adds exactly one cycle of latency.
- A new `start` can be accepted in the DONE cycle, which gives back-to-back operation.

## Configuration
- `MDU_HILO_EN` defined:
  - HI/LO registers are built in.
  - They load `res_hi`/`res_lo` on the `done` edge.
  - `hilo_we` writes the selected half from `hilo_wdata`.
  - When `hilo_we` and `done` hit the same half in the same cycle, `hilo_we` wins. The other half takes the result.
- Undefined: the `hilo_we`, `hilo_wdata`, `hi` and `lo` ports and the HI/LO registers are removed. HILO stays external.

## Structure
- Package `mdu_pkg` holds:
  - the op encoding constants `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - the state encoding;
  - the `MUL_BITS` legality check.
- Sub-module `mdu_div_step`: one combinational restoring-division step (partial remainder, divisor in; next remainder and quotient bit out). It is instantiated once inside the DIV loop.

## Test plan
- MULT −3 × 7, WIDTH=32, MUL_BITS=1 → `done` at cycle 34, `res_hi`=FFFFFFFF, `res_lo`=FFFFFFEB. Repeat with MUL_BITS=4 → `done` at cycle 10, same result.
- DIVU 100/7 → `res_lo`=14, `res_hi`=2. DIV −7/2 → `res_lo`=FFFFFFFD, `res_hi`=FFFFFFFF.
- DIV 80000000/FFFFFFFF → `res_lo`=80000000, `res_hi`=0, `div_zero`=0. DIVU 5/0 → `done` at cycle 2, `res_lo`=FFFFFFFF, `res_hi`=5, `div_zero`=1.
- MULTU with `en`=0 for 10 cycles mid-operation → `done` at cycle 44 with the correct product.
- Flush at cycle 5 → no `done`, `busy`=0 next cycle, prior `res_*` held. A `start` in the following cycle is accepted.
- With `MDU_HILO_EN`: `hilo_we`=10, `hilo_wdata`=1234 in the `done` cycle of 2×3 → `hi`=1234, `lo`=6. `rst`=0 mid-operation → all outputs 0 and state IDLE next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and configuration checks for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  // Per-operation context captured at accept time.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
    logic dz;
  } mdu_ctx_t;

  function automatic bit mul_bits_ok(int unsigned width, int unsigned mul_bits);
    return ((mul_bits == 1) || (mul_bits == 2) || (mul_bits == 4)) &&
           ((width % mul_bits) == 0) && (width >= 8) && ((width % 2) == 0);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: compare/subtract the shifted partial remainder against the divisor.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_c_o,
  output logic             qbit_c_o
);

  logic [WIDTH:0] divx;

  assign divx     = {1'b0, div_i};
  assign qbit_c_o = (rem_i >= divx);
  // A successful subtract always leaves a value below the divisor, so it fits in WIDTH bits.
  assign rem_c_o  = qbit_c_o ? WIDTH'(rem_i - divx) : rem_i[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with start/busy/done handshake, stall freeze and flush cancel.
// Optional HI/LO architectural registers are built when MDU_HILO_EN is defined.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
`ifdef MDU_HILO_EN
  ,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`endif
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = WIDTH + MUL_BITS;
  localparam int unsigned MUL_N = WIDTH / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (!mul_bits_ok(WIDTH, MUL_BITS)) begin : g_bad_cfg
    $error("mdu_iter: illegal WIDTH/MUL_BITS combination");
  end

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  mdu_ctx_t         ctx_q, ctx_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             dz_q, dz_d, busy_q, busy_d, done_q, done_d;

  logic             is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [SW-1:0]    mul_sum;
  logic [PW-1:0]    acc_mul, acc_div, prod_s;
  logic [WIDTH:0]   div_rem_in;
  logic [WIDTH-1:0] div_rem_nxt, quo_s, rem_s;
  logic             div_qbit;

  // Operand decode: signed ops work on magnitudes, signs are re-applied in FIX.
  always_comb begin : operand_decode
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    a_neg     = is_signed & src_a[WIDTH-1];
    b_neg     = is_signed & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
  end

  // Shift-add step: multiplier sits in the low half of acc and retires MUL_BITS per cycle.
  always_comb begin : mul_step
    mul_sum = SW'(acc_q[PW-1:WIDTH]);
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (acc_q[i]) mul_sum = mul_sum + (SW'(opb_q) << i);
    end
    acc_mul = {mul_sum, acc_q[WIDTH-1:MUL_BITS]};
  end

  assign div_rem_in = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i    (div_rem_in),
    .div_i    (opb_q),
    .rem_c_o  (div_rem_nxt),
    .qbit_c_o (div_qbit)
  );

  assign acc_div = {div_rem_nxt, acc_q[WIDTH-2:0], div_qbit};

  always_comb begin : sign_fix
    prod_s = ctx_q.neg_res ? -acc_q : acc_q;
    quo_s  = ctx_q.neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = ctx_q.neg_rem ? -acc_q[PW-1:WIDTH] : acc_q[PW-1:WIDTH];
  end

  always_comb begin : next_state
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    ctx_d    = ctx_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dz_d     = dz_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (en) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start) begin
            cnt_d         = '0;
            opb_d         = is_div ? b_mag : a_mag;
            ctx_d.is_div  = is_div;
            ctx_d.neg_res = a_neg ^ b_neg;
            ctx_d.neg_rem = a_neg;
            ctx_d.dz      = is_div && (src_b == '0);
            if (!is_div) begin
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              state_d = ST_MUL;
            end else if (src_b == '0) begin
              // Raw dividend is parked so FIX can return it unchanged.
              acc_d   = {{WIDTH{1'b0}}, src_a};
              state_d = ST_FIX;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          acc_d = acc_mul;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_N - 1)) state_d = ST_FIX;
        end
        ST_DIV: begin
          acc_d = acc_div;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_DONE;
          if (ctx_q.dz) begin
            res_hi_d = acc_q[WIDTH-1:0];
            res_lo_d = '1;
            dz_d     = 1'b1;
          end else if (ctx_q.is_div) begin
            res_hi_d = rem_s;
            res_lo_d = quo_s;
            dz_d     = 1'b0;
          end else begin
            {res_hi_d, res_lo_d} = prod_s;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      ctx_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      ctx_q    <= ctx_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_hi   = res_hi_q;
  assign res_lo   = res_lo_q;
  assign div_zero = dz_q;

`ifdef MDU_HILO_EN
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Results land on the done edge; an explicit MTHI/MTLO to the same half takes precedence.
  always_comb begin : hilo_next
    hi_d = hi_q;
    lo_d = lo_q;
    if (done_q) begin
      hi_d = res_hi_q;
      lo_d = res_lo_q;
    end
    if (hilo_we[1]) hi_d = hilo_wdata;
    if (hilo_we[0]) lo_d = hilo_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule
